// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an icache refill port and a data port,
// with round-robin or fixed data priority and a per-transaction timeout.
module mem_arbiter #(
    parameter int unsigned TIMEOUT    = 255,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [19:0] i_addr,
    output logic        i_fetch,
    output logic [31:0] i_data,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [19:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [19:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
    state_t state, state_nx;
    logic [7:0] cnt;
    logic grant, gsel, tmo, fin;
    always_comb begin
        gsel     = (i_req && d_req) ? (FIXED_PRIO ? 1'b1 : ~owner) : d_req;
        grant    = (state == IDLE) && (i_req || d_req);
        mem_req  = (state == BUSY_I) || (state == BUSY_D);
        busy     = state != IDLE;
        // a same-cycle ack always wins over the timeout
        tmo      = !mem_ack && (cnt == 8'(TIMEOUT - 1));
        fin      = mem_req && (mem_ack || tmo);
        i_fetch  = (state == RESP) && !owner;
        d_done   = (state == RESP) && owner;
        state_nx = IDLE;
        case (state)
            IDLE:           state_nx = grant ? (gsel ? BUSY_D : BUSY_I) : IDLE;
            BUSY_I, BUSY_D: state_nx = fin ? RESP : state;
            default:        state_nx = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= 1'b1;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            i_data    <= '0;
            d_rdata   <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner     <= gsel;
                cnt       <= '0;
                mem_addr  <= gsel ? d_addr : i_addr;
                mem_we    <= gsel && d_we;
                mem_wdata <= gsel ? d_wdata : '0;
                mem_wmask <= gsel ? d_wmask : '0;
            end else if (mem_req && !mem_ack) begin
                cnt <= cnt + 8'd1;
            end
            if (fin && owner)
                d_rdata <= mem_ack ? mem_rdata : '0;
            if (fin && !owner)
                i_data <= mem_ack ? mem_rdata : '0;
            if (fin && !mem_ack)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives a round-robin and a fixed-priority arbiter with the same
// directed stimulus and checks both against a transaction-level model every cycle.
module tb_mem_arbiter;
    localparam int TMO = 4;
    logic        CLK = 1'b0;
    logic        resetn = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [19:0] i_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0, mem_rdata = '0;
    logic [3:0]  d_wmask = '0;
    logic [1:0]  i_fetch, d_done, mem_req, mem_we, busy, owner, err;
    logic [31:0] i_data [2];
    logic [31:0] d_rdata [2];
    logic [31:0] mem_wdata [2];
    logic [19:0] mem_addr [2];
    logic [3:0]  mem_wmask [2];
    int vectors = 0, miscompares = 0;
    always #5 CLK = ~CLK;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.TIMEOUT(TMO), .FIXED_PRIO(g == 1)) u_dut (
            .CLK(CLK), .resetn(resetn),
            .i_req(i_req), .i_addr(i_addr), .i_fetch(i_fetch[g]), .i_data(i_data[g]),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_wmask(d_wmask), .d_done(d_done[g]), .d_rdata(d_rdata[g]),
            .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_wmask(mem_wmask[g]),
            .mem_ack(mem_ack), .mem_rdata(mem_rdata),
            .busy(busy[g]), .owner(owner[g]), .err(err[g])
        );
    end
    // transaction-level model: one outstanding transaction, one response cycle after it
    bit          m_act [2], m_due [2], m_own [2], m_err [2], m_we [2], m_dknown [2];
    int          m_age [2];
    logic [19:0] m_addr [2];
    logic [31:0] m_wdata [2], m_idat [2], m_ddat [2];
    logic [3:0]  m_wmask [2];
    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL dut%0d %s: got %h expected %h at %0t", k, nm, act, exp, $time);
        end
    endtask
    task automatic complete(input int k, input logic [31:0] v, input bit to);
        m_act[k] = 1'b0;
        m_due[k] = 1'b1;
        if (m_own[k]) begin
            m_ddat[k]   = v;
            m_dknown[k] = !m_we[k] || to;
        end else begin
            m_idat[k] = v;
        end
        if (to) m_err[k] = 1'b1;
    endtask
    always @(posedge CLK or negedge resetn) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                m_act[k] = 0; m_due[k] = 0; m_own[k] = 1; m_err[k] = 0; m_we[k] = 0;
                m_dknown[k] = 1; m_age[k] = 0; m_addr[k] = '0; m_wdata[k] = '0;
                m_wmask[k] = '0; m_idat[k] = '0; m_ddat[k] = '0;
            end else if (m_act[k]) begin
                if (mem_ack) complete(k, mem_rdata, 1'b0);
                else begin
                    m_age[k]++;
                    if (m_age[k] == TMO) complete(k, 32'h0, 1'b1);
                end
            end else if (m_due[k]) begin
                m_due[k] = 1'b0;
            end else if (i_req || d_req) begin
                m_own[k]   = (i_req && d_req) ? (k == 1 ? 1'b1 : !m_own[k]) : d_req;
                m_act[k]   = 1'b1;
                m_age[k]   = 0;
                m_addr[k]  = m_own[k] ? d_addr : i_addr;
                m_we[k]    = m_own[k] && d_we;
                m_wdata[k] = d_wdata;
                m_wmask[k] = m_own[k] ? d_wmask : 4'h0;
            end
        end
    end
    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            chk(k, "mem_req", 32'(mem_req[k]), 32'(m_act[k]));
            chk(k, "busy", 32'(busy[k]), 32'(m_act[k] || m_due[k]));
            chk(k, "owner", 32'(owner[k]), 32'(m_own[k]));
            chk(k, "err", 32'(err[k]), 32'(m_err[k]));
            chk(k, "i_fetch", 32'(i_fetch[k]), 32'(m_due[k] && !m_own[k]));
            chk(k, "d_done", 32'(d_done[k]), 32'(m_due[k] && m_own[k]));
            chk(k, "i_data", i_data[k], m_idat[k]);
            if (m_dknown[k]) chk(k, "d_rdata", d_rdata[k], m_ddat[k]);
            if (m_act[k]) begin
                chk(k, "mem_addr", 32'(mem_addr[k]), 32'(m_addr[k]));
                chk(k, "mem_we", 32'(mem_we[k]), 32'(m_we[k]));
                chk(k, "mem_wmask", 32'(mem_wmask[k]), 32'(m_wmask[k]));
                if (m_we[k]) chk(k, "mem_wdata", mem_wdata[k], m_wdata[k]);
            end
        end
    end
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask
    int gq0 [$], gq1 [$];
    int cnt;
    bit prev0, prev1, seen;
    initial begin
        #1 resetn = 1'b0;
        #1;
        chk(0, "rst owner", 32'(owner[0]), 32'd1);
        chk(0, "rst mem_req", 32'(mem_req[0]), 32'd0);
        chk(0, "rst mem_addr", 32'(mem_addr[0]), 32'd0);
        chk(1, "rst d_rdata", d_rdata[1], 32'd0);
        tick(2);
        resetn = 1'b1;
        tick();
        // single refill, ack two cycles after mem_req rises
        i_req = 1'b1; i_addr = 20'h00404;
        tick();
        chk(0, "refill mem_req", 32'(mem_req[0]), 32'd1);
        chk(0, "refill mem_addr", 32'(mem_addr[0]), 32'h00404);
        chk(0, "refill mem_we", 32'(mem_we[0]), 32'd0);
        tick(2);
        mem_ack = 1'b1; mem_rdata = 32'h00B70023;
        tick();
        mem_ack = 1'b0; i_req = 1'b0;
        chk(0, "refill i_fetch", 32'(i_fetch[0]), 32'd1);
        chk(0, "refill i_data", i_data[0], 32'h00B70023);
        tick();
        chk(0, "refill one pulse", 32'(i_fetch[0]), 32'd0);
        // store; address changes after the grant edge must be ignored
        d_req = 1'b1; d_we = 1'b1; d_addr = 20'h00010; d_wdata = 32'hDEADBEEF; d_wmask = 4'b0011;
        tick();
        d_addr = 20'hFFFFC; d_wdata = 32'h0; d_wmask = 4'hF;
        chk(0, "store mem_addr", 32'(mem_addr[0]), 32'h00010);
        chk(0, "store mem_wdata", mem_wdata[0], 32'hDEADBEEF);
        chk(0, "store mem_wmask", 32'(mem_wmask[0]), 32'h3);
        chk(0, "store mem_we", 32'(mem_we[0]), 32'd1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        tick();
        mem_ack = 1'b0; d_req = 1'b0;
        chk(0, "store d_done", 32'(d_done[0]), 32'd1);
        tick();
        // load with immediate ack
        d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00100;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0; d_req = 1'b0;
        chk(0, "load d_rdata", d_rdata[0], 32'h12345678);
        tick();
        // contention straight after reset, ack always available
        resetn = 1'b0;
        #1 resetn = 1'b1;
        i_req = 1'b1; d_req = 1'b1; i_addr = 20'h00500; d_addr = 20'h00600; mem_ack = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        prev0 = 0; prev1 = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (mem_req[0] && !prev0) gq0.push_back(int'(owner[0]));
            if (mem_req[1] && !prev1) gq1.push_back(int'(owner[1]));
            prev0 = mem_req[0]; prev1 = mem_req[1];
        end
        chk(0, "rr grant count", 32'(gq0.size()), 32'd4);
        chk(1, "fp grant count", 32'(gq1.size()), 32'd4);
        for (int i = 0; i < 4 && i < gq0.size(); i++) chk(0, "rr grant seq", 32'(gq0[i]), 32'(i % 2));
        for (int i = 0; i < 4 && i < gq1.size(); i++) chk(1, "fp grant seq", 32'(gq1[i]), 32'd1);
        d_req = 1'b0;
        tick();
        chk(1, "fp instr after d drop", 32'(owner[1]), 32'd0);
        tick();
        i_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        // ack in the same cycle the timeout would fire
        i_req = 1'b1; i_addr = 20'h00800;
        tick();
        i_req = 1'b0;
        tick(3);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        chk(0, "late ack i_fetch", 32'(i_fetch[0]), 32'd1);
        chk(0, "late ack i_data", i_data[0], 32'hCAFEF00D);
        chk(0, "late ack err", 32'(err[0]), 32'd0);
        tick();
        // timeout on a load; requester drops its request mid-transaction
        d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00200;
        tick();
        d_req = 1'b0;
        cnt = 0; seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_req[0]) cnt++;
            if (d_done[0]) begin
                seen = 1;
                chk(0, "timeout d_rdata", d_rdata[0], 32'd0);
            end
            tick();
        end
        chk(0, "timeout mem_req cycles", 32'(cnt), 32'(TMO));
        chk(0, "timeout d_done seen", 32'(seen), 32'd1);
        chk(0, "timeout err", 32'(err[0]), 32'd1);
        // reset while an instruction transaction is outstanding
        i_req = 1'b1; i_addr = 20'h00900;
        tick(2);
        chk(0, "pre-reset busy", 32'(busy[0]), 32'd1);
        resetn = 1'b0;
        #1;
        chk(0, "async reset mem_req", 32'(mem_req[0]), 32'd0);
        chk(0, "async reset busy", 32'(busy[0]), 32'd0);
        chk(0, "async reset err", 32'(err[0]), 32'd0);
        tick(2);
        chk(0, "reset no i_fetch", 32'(i_fetch[0]), 32'd0);
        resetn = 1'b1;
        tick();
        chk(0, "first edge after reset", 32'(mem_req[0]), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        tick();
        mem_ack = 1'b0; i_req = 1'b0;
        chk(0, "post-reset i_data", i_data[0], 32'h0BADF00D);
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of cycles mem_req is held without mem_ack before the transaction is aborted; legal range 1..255.
REQ-002 Parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration; 1 gives the data port fixed priority over the instruction port.
REQ-003 CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 resetn  in  1  reset; asynchronous and active-low.
REQ-005 i_req  in  1  instruction-cache refill request (icache miss); level, held until i_fetch.
REQ-006 i_addr  in  20  refill byte address; bits [1:0] are ignored.
REQ-007 i_fetch  out  1  one-cycle pulse: refill word valid on i_data.
REQ-008 i_data  out  32  refill word.
REQ-009 d_req  in  1  data request; level, held until d_done.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr  in  20  data byte address; bits [1:0] are ignored.
REQ-012 d_wdata  in  32  store data.
REQ-013 d_wmask  in  4  store byte enables.
REQ-014 d_done  out  1  one-cycle pulse: data transaction complete.
REQ-015 d_rdata  out  32  load data; valid while d_done is high.
REQ-016 mem_req, mem_we  out  1 each  request and write strobe to the shared memory.
REQ-017 mem_addr  out  20  memory address.
REQ-018 mem_wdata  out  32  memory write data.
REQ-019 mem_wmask  out  4  memory write byte enables.
REQ-020 mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
REQ-021 mem_rdata  in  32  memory read data.
REQ-022 busy  out  1  high in every state other than IDLE.
REQ-023 owner  out  1  current or last grant: 0 = instruction port, 1 = data port.
REQ-024 err  out  1  sticky timeout flag.

Function
REQ-025 FSM states are IDLE, BUSY_I, BUSY_D and RESP; no other state is reachable, and any illegal encoding returns to IDLE.
REQ-026 IDLE, requests are sampled:
- only i_req high: go to BUSY_I.
- only d_req high: go to BUSY_D.
- neither high: remain in IDLE.
REQ-027 IDLE, i_req and d_req both high:
- FIXED_PRIO=1: grant the data port.
- FIXED_PRIO=0: grant the port opposite to owner, then update owner to the granted port.
REQ-028 Grant capture: address, we, wdata and wmask of the granted port are registered into the mem_* outputs on the granting edge; requester changes after that edge are ignored until RESP.
REQ-029 Instruction grants drive mem_we=0 and mem_wmask=0.
REQ-030 Grant timing: a request sampled high in IDLE at cycle N gives mem_req=1 at cycle N+1.
REQ-031 mem_req stays high and the mem_* fields stay stable until the cycle in which mem_ack=1 is sampled.
REQ-032 mem_ack at cycle M, in BUSY_I or BUSY_D:
- at M+1: mem_req=0, state is RESP, and exactly one of i_fetch or d_done pulses, with i_data or d_rdata equal to mem_rdata registered at M.
REQ-033 Stores also return d_done; d_rdata is a don't-care for stores.
REQ-034 RESP lasts exactly one cycle, then the FSM enters IDLE; requests are ignored during RESP, so the earliest next grant edge is M+2 and the earliest next mem_req is M+3.
REQ-035 i_data and d_rdata hold their last value between pulses.
REQ-036 Timeout counter: 8 bits, cleared on every grant, increments each BUSY cycle with mem_ack=0.
REQ-037 Timeout: when the counter reaches TIMEOUT, the next state is RESP with mem_req=0, the response pulse is issued with data 32'h00000000, and err is set to 1.
REQ-038 mem_ack in the same cycle as the timeout takes precedence: a normal completion, and err is unchanged.
REQ-039 mem_ack while mem_req=0 is ignored.
REQ-040 A requester that drops its request mid-transaction does not abort it; the memory transaction and the response pulse still complete.
REQ-041 i_fetch and d_done are never high in the same cycle, and neither is ever high for two consecutive cycles.

Reset
REQ-042 resetn=0 forces, asynchronously, the following values:
- state IDLE, timeout counter 0.
- mem_req, mem_we, i_fetch, d_done, busy and err all 0.
- mem_addr, mem_wdata, mem_wmask, i_data and d_rdata all 0.
- owner 1, so the first simultaneous request under round-robin is granted to the instruction port.
REQ-043 Reset asserted mid-transaction drops mem_req immediately and issues no response pulse; after release, the first rising edge with resetn=1 behaves as IDLE.

Verification
REQ-044 Single refill: i_req=1, i_addr=20'h00404, mem_ack two cycles after mem_req with mem_rdata=32'h00B70023 -> mem_addr=20'h00404, mem_we=0, one i_fetch pulse with i_data=32'h00B70023.
REQ-045 Round-robin contention: FIXED_PRIO=0, both requests held after reset, ack after one cycle -> grants alternate I, D, I, D; no port is granted twice in a row.
REQ-046 Fixed priority: FIXED_PRIO=1, both requests high -> data port granted first; instruction granted only after d_req drops.
REQ-047 Store: d_we=1, d_addr=20'h00010, d_wdata=32'hDEADBEEF, d_wmask=4'b0011 -> mem_* match these values until mem_ack, then one d_done pulse.
REQ-048 Timeout: TIMEOUT=4, mem_ack never asserted -> mem_req high for exactly 4 cycles, then d_done pulse with d_rdata=0, err=1 held until resetn=0.
REQ-049 Reset mid-operation: resetn=0 while in BUSY_I -> mem_req=0 with no clock edge, no i_fetch pulse, busy=0.
